fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 140 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ burst producers.
// Define ARB_WDOG_EN to add the idle-owner watchdog and its wdog_evt output.

module fifo_wr_arbiter_lane #(
  parameter int GW = 2,
  parameter int ID = 0
) (
  input  logic          xfer_ok,
  input  logic [GW-1:0] grant_id,
  input  logic          valid,
  output logic          ready
);
  assign ready = xfer_ok & valid & (grant_id == GW'(ID));
endmodule

module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4,
  parameter int WDOG_CYC  = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_last,
  input  logic [NREQ*DATA_W-1:0]    req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wen,
  output logic [DATA_W-1:0]         fifo_wdata,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      stall
`ifdef ARB_WDOG_EN
  ,
  output logic                      wdog_evt
`endif
);
  localparam int GW = $clog2(NREQ);
  localparam int CW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  typedef enum logic [1:0] {IDLE, XFER, STALL} state_t;

  state_t                       state, state_d;
  logic [GW-1:0]                last_gnt, last_d, gnt_d, pick, idx;
  logic [CW-1:0]                cnt, cnt_d;
  logic                         any, own_vld, xfer_ok, wdog_hit;
  logic [NREQ-1:0][DATA_W-1:0]  data_a;

  assign data_a     = req_data;
  assign fifo_wdata = data_a[grant_id];
  assign own_vld    = req_valid[grant_id];
  assign xfer_ok    = (state == XFER) & ~fifo_full;
  assign fifo_wen   = |req_ready;
  assign busy       = (state != IDLE);
  assign stall      = (state == STALL);

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    fifo_wr_arbiter_lane #(.GW(GW), .ID(i)) u_lane (
      .xfer_ok  (xfer_ok),
      .grant_id (grant_id),
      .valid    (req_valid[i]),
      .ready    (req_ready[i])
    );
  end

  // Walk downward so the nearest index after last_gnt wins.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = GW'((int'(last_gnt) + k) % NREQ);
      if (req_valid[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

`ifdef ARB_WDOG_EN
  localparam int IW = $clog2(WDOG_CYC + 1);
  logic [IW-1:0] idle_cnt;

  assign wdog_hit = (state == XFER) & ~own_vld & (idle_cnt == IW'(WDOG_CYC - 1));
  assign wdog_evt = wdog_hit;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn)                                        idle_cnt <= '0;
    else if ((state == XFER) && !own_vld && !wdog_hit) idle_cnt <= idle_cnt + 1'b1;
    else                                              idle_cnt <= '0;
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    state_d = state;
    gnt_d   = grant_id;
    last_d  = last_gnt;
    cnt_d   = cnt;
    case (state)
      IDLE: if (any) begin
        gnt_d   = pick;
        state_d = XFER;
      end
      XFER: begin
        if (fifo_wen) begin
          if (req_last[grant_id] || (cnt == CW'(BURST_MAX - 1))) begin
            last_d  = grant_id;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end else if (own_vld && fifo_full) begin
          state_d = STALL;
        end else if (wdog_hit) begin
          last_d  = grant_id;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      STALL: if (!fifo_full) state_d = XFER;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state    <= IDLE;
      grant_id <= '0;
      last_gnt <= GW'(NREQ - 1);
      cnt      <= '0;
    end else begin
      state    <= state_d;
      grant_id <= gnt_d;
      last_gnt <= last_d;
      cnt      <= cnt_d;
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: queued producers, hand-ordered expected beats,
// and cycle traces of fifo_wen/busy/stall for timing.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4, DW = 8, BMAX = 4, WDOG = 16;

  logic                 clk = 1'b0, rstn = 1'b1;
  logic [NREQ-1:0]      req_valid, req_last, req_ready;
  logic [NREQ*DW-1:0]   req_data;
  logic                 fifo_full = 1'b0, fifo_wen, busy, stall;
  logic [DW-1:0]        fifo_wdata;
  logic [1:0]           grant_id;
`ifdef ARB_WDOG_EN
  logic                 wdog_evt;
`endif

  typedef struct packed { logic [1:0] id; logic [DW-1:0] data; } beat_t;
  beat_t           sbq[$];
  logic [DW:0]     pmem [NREQ][64];
  int              phead [NREQ];
  int              ptail [NREQ];
  logic [NREQ-1:0] take = '0;
  int              tests = 0, fails = 0;
  logic [31:0]     w, b, s, e;

  fifo_wr_arbiter #(.NREQ(NREQ), .DATA_W(DW), .BURST_MAX(BMAX), .WDOG_CYC(WDOG)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .grant_id(grant_id),
    .busy(busy), .stall(stall)
`ifdef ARB_WDOG_EN
    , .wdog_evt(wdog_evt)
`endif
  );

  always #5 clk = ~clk;

  // Producers present the head of their beat queue whenever it is non-empty.
  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < NREQ; i++)
      if (phead[i] != ptail[i]) begin
        req_valid[i]          = 1'b1;
        req_last[i]           = pmem[i][phead[i]][DW];
        req_data[i*DW +: DW]  = pmem[i][phead[i]][DW-1:0];
      end
  end

  initial forever begin
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) if (take[i]) phead[i] = phead[i] + 1;
  end

  // Monitor: every accepted beat must match the next expected beat.
  initial begin : mon
    beat_t x;
    forever begin
      @(negedge clk);
      take = rstn ? req_ready : '0;
      if (rstn && fifo_wen) begin
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL sb_extra: got id=%0d data=%0h, expected no beat", grant_id, fifo_wdata);
        end else begin
          x = sbq.pop_front();
          if ({grant_id, fifo_wdata} !== x) begin
            fails++;
            $display("FAIL sb_beat: got id=%0d data=%0h, expected id=%0d data=%0h",
                     grant_id, fifo_wdata, x.id, x.data);
          end
          tests++;
          if (req_ready !== (4'b0001 << x.id)) begin
            fails++;
            $display("FAIL sb_ready: got %b, expected one-hot of %0d", req_ready, x.id);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [DW-1:0] d, input logic l);
    pmem[i][ptail[i]] = {l, d};
    ptail[i] = ptail[i] + 1;
  endtask

  task automatic exp_beat(input logic [1:0] id, input logic [DW-1:0] d);
    sbq.push_back({id, d});
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  // Starts at posedge+1 (cycle 0); fifo_full raised at cycle fon, dropped at foff.
  task automatic run_trace(input int n, input int fon, input int foff,
                           output logic [31:0] wt, output logic [31:0] bt,
                           output logic [31:0] st, output logic [31:0] et);
    wt = '0; bt = '0; st = '0; et = '0;
    for (int k = 0; k < n; k++) begin
      if (k == fon)  fifo_full = 1'b1;
      if (k == foff) fifo_full = 1'b0;
      @(negedge clk);
      wt[k] = fifo_wen;
      bt[k] = busy;
      st[k] = stall;
`ifdef ARB_WDOG_EN
      et[k] = wdog_evt;
`endif
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1 rstn = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_wen", 32'(fifo_wen), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_grant", 32'(grant_id), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Single 3-beat burst from req0.
    push(0, 8'h11, 0); push(0, 8'h22, 0); push(0, 8'h33, 1);
    exp_beat(0, 8'h11); exp_beat(0, 8'h22); exp_beat(0, 8'h33);
    run_trace(6, -1, -1, w, b, s, e);
    chk("t1_wen", w, 32'b001110);
    chk("t1_busy", b, 32'b001110);

    // req0 and req2 2-beat bursts from reset priority: one idle cycle between.
    do_reset();
    push(0, 8'h40, 0); push(0, 8'h41, 1);
    push(2, 8'h60, 0); push(2, 8'h61, 1);
    exp_beat(0, 8'h40); exp_beat(0, 8'h41); exp_beat(2, 8'h60); exp_beat(2, 8'h61);
    run_trace(7, -1, -1, w, b, s, e);
    chk("t2_wen", w, 32'b0110110);

    // All four requesting: rotation 0,1,2,3,0,1,2,3.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      push(i, 8'hA0 + 8'(i), 1);
      push(i, 8'hA4 + 8'(i), 1);
    end
    for (int j = 0; j < 8; j++) exp_beat(2'(j % 4), 8'hA0 + 8'(j));
    run_trace(17, -1, -1, w, b, s, e);
    chk("t2_rr_wen", w, 32'h0AAAA);

    // req1 streams 10 beats; BURST_MAX splits 4,4,2 with req0/req3 interleaved.
    push(0, 8'hB0, 1);
    push(3, 8'hB3, 1);
    for (int j = 0; j < 10; j++) push(1, 8'h10 + 8'(j), (j == 9) ? 1'b1 : 1'b0);
    exp_beat(0, 8'hB0);
    for (int j = 0; j < 4; j++) exp_beat(1, 8'h10 + 8'(j));
    exp_beat(3, 8'hB3);
    for (int j = 4; j < 10; j++) exp_beat(1, 8'h10 + 8'(j));
    run_trace(18, -1, -1, w, b, s, e);
    chk("t3_wen", w, 32'b011011110101111010);

    // req3 burst with fifo_full high for cycles 3..7.
    for (int j = 0; j < 6; j++) push(3, 8'hC0 + 8'(j), (j == 5) ? 1'b1 : 1'b0);
    for (int j = 0; j < 6; j++) exp_beat(3, 8'hC0 + 8'(j));
    run_trace(15, 3, 8, w, b, s, e);
    chk("t4_wen", w, 32'b011011000000110);
    chk("t4_stall", s, 32'b000000111110000);

    // Reset asserted during the 2nd beat of a req2 burst.
    for (int j = 0; j < 4; j++) push(2, 8'hD0 + 8'(j), (j == 3) ? 1'b1 : 1'b0);
    exp_beat(2, 8'hD0); exp_beat(2, 8'hD1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_pre_wen", 32'(fifo_wen), 1);
    #2 rstn = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_wen", 32'(fifo_wen), 0);
    chk("t5_ready", 32'(req_ready), 0);
    chk("t5_grant", 32'(grant_id), 0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    for (int i = 0; i < NREQ; i++) ptail[i] = phead[i];
    push(1, 8'hE1, 1);
    push(0, 8'hE0, 1);
    exp_beat(0, 8'hE0); exp_beat(1, 8'hE1);
    @(posedge clk); #1;
    rstn = 1'b1;
    run_trace(5, -1, -1, w, b, s, e);
    chk("t5_after_wen", w, 32'b01010);

`ifdef ARB_WDOG_EN
    // req0 goes silent after one beat; watchdog hands the port to req1.
    push(0, 8'hF0, 0);
    push(1, 8'hF1, 1);
    exp_beat(0, 8'hF0); exp_beat(1, 8'hF1);
    run_trace(22, -1, -1, w, b, s, e);
    chk("t6_evt", e, 32'h020000);
    chk("t6_wen", w, 32'h080002);
`endif

    for (int c = 0; c < 50 && (busy || sbq.size() != 0); c++) @(posedge clk);
    #1;
    chk("drain_sb", 32'(sbq.size()), 0);
    chk("drain_busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
